instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Program loader that fills the byte-addressable, big-endian instruction memory from a byte stream before the core starts fetching. It accepts bytes over a valid/ready handshake, packs them MSB-first into 32-bit words, and issues one word write per four bytes (byte-enabled partial write for a trailing fragment). It sits between the boot/debug byte source and the instruction memory write port. It reports completion or overflow to the reset/boot controller.

## Interface
- MEM_BYTES, 64, memory capacity in bytes; multiple of 4.
- ADDR_W, 32, width of address and byte counter.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; begins a load at address 0.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in valid.
- byte_last  in  1  qualifies byte_in as the final byte of the image.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  one-cycle word write strobe.
- mem_addr  out  ADDR_W  word-aligned byte address of write.
- mem_wdata  out  32  big-endian word: [31:24]→addr, [7:0]→addr+3.
- mem_be  out  4  byte enables: be[3]→addr … be[0]→addr+3.
- busy  out  1  load in progress.
- done  out  1  image fully written.
- error  out  1  image exceeded MEM_BYTES.
- bytes_loaded  out  ADDR_W  count of accepted bytes.

## Operation
- States: IDLE, FILL, WRITE, DONE, ERR.
- IDLE: byte_ready=0. start → FILL, with addr, byte index and count set to 0.
- FILL: byte_ready=1. On a transfer (byte_valid & byte_ready), the byte goes to lane (3−idx) of the shift register; idx++ and bytes_loaded++. After the 4th byte, or after any byte with byte_last=1 → WRITE.
- WRITE: byte_ready=0.
  - mem_we=1, mem_addr=addr, mem_wdata=packed word.
  - mem_be has ones for filled lanes only (4'b1111 full, 4'b1100 for 2 bytes, etc.). Unfilled lanes drive 8'h00.
  - Next state:
    - last seen → DONE.
    - else if addr+4 == MEM_BYTES → ERR.
    - else addr+=4, idx=0 → FILL.
- DONE: done=1. ERR: error=1. Both hold until reset or start; start restarts the load from address 0 and clears done/error and bytes_loaded.
- start while busy is ignored. byte_valid outside FILL is ignored; no transfer is counted.
- byte_last with idx=3 (4th byte) gives a full word; be=4'b1111.
- An image of exactly MEM_BYTES bytes with byte_last on the final byte ends in DONE, not ERR.
- Arithmetic: addr and bytes_loaded are ADDR_W unsigned. addr never exceeds MEM_BYTES−4, so there is no wrap.

## Timing
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, busy=0, done=0, error=0, bytes_loaded=0, state IDLE.
- All outputs are registered.
- start sampled at cycle t → byte_ready=1 at t+1.
- Final byte of a word accepted at cycle n → mem_we=1 at n+1 for exactly one cycle, with byte_ready=0 that cycle; byte_ready=1 again at n+2.
- Sustained throughput: 4 bytes per 5 cycles.
- DONE/ERR asserted the cycle after the WRITE cycle.
- Reset asserted in any state (including WRITE) → IDLE next edge. No mem_we is issued after the reset edge; memory contents are not altered.

## Structure
- Shared package loader_pkg holds:
  - the state enum;
  - BYTES_PER_WORD=4;
  - PAD_BYTE=8'h00;
  - the byte-lane mapping function (lane → data bit slice).
- Natural sub-module: be_word_packer. It holds the shift register, byte index, enables, and big-endian lane placement, with clear/load/full outputs. The FSM and address counter stay in the top module.

## Test plan
- Stream 84 04 12 32 25 43 17 89 (last on 89) → writes addr 0 data 84041232 be F, then addr 4 data 25431789 be F. Then done=1, bytes_loaded=8.
- Stream 23 53 97 (last on 97) → addr 0, data 23539700, be 1110, done=1, bytes_loaded=3.
- MEM_BYTES=8, stream 12 bytes with no last → two writes (addr 0, 4), then error=1, byte_ready=0, bytes_loaded=8.
- byte_valid toggling every other cycle over 4 bytes → still exactly one write of the correct word. No transfer is counted while byte_ready=0 in WRITE.
- Reset asserted on the cycle after the 4th byte is accepted → no mem_we, all outputs return to reset values. A following start and 4 bytes 29 48 19 99 → addr 0 data 29481999.
- start pulsed during FILL, then again in DONE → first ignored; second restarts at addr 0 and clears done.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader: FSM states,
// word geometry and the big-endian byte-lane placement helper.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] PAD_BYTE       = 8'h00;

  // Lane 3 is the lowest byte address and therefore occupies bits [31:24].
  function automatic int unsigned lane_lsb(input logic [1:0] lane);
    return int'(lane) << 3;
  endfunction

endpackage

// File: rtl/be_word_packer.sv
// Packs a byte stream MSB-first into a 32-bit word and tracks which lanes
// have been filled; exposes the word/enables as they will be after this load.
module be_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word_nxt,
  output logic [3:0]  be_nxt,
  output logic        full
);

  logic [31:0] word_q;
  logic [3:0]  be_q;
  logic [1:0]  idx_q;
  logic [1:0]  lane;

  assign lane = 2'd3 - idx_q;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    word_nxt = word_q;
    be_nxt   = be_q;
    full     = 1'b0;
    if (load) begin
      word_nxt[lane_lsb(lane) +: 8] = data;
      be_nxt[lane]                  = 1'b1;
      full                          = (idx_q == 2'(BYTES_PER_WORD - 1));
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word_q <= {BYTES_PER_WORD{PAD_BYTE}};
      be_q   <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= word_nxt;
      be_q   <= be_nxt;
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time program loader: accepts a byte stream, writes it as big-endian
// words into instruction memory and reports done/overflow.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] bytes_loaded
);

  state_t      state, next_state;
  logic        restart, clear, load, full, last_seen;
  logic [31:0] word_nxt;
  logic [3:0]  be_nxt;

  be_word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .load     (load),
    .data     (byte_in),
    .word_nxt (word_nxt),
    .be_nxt   (be_nxt),
    .full     (full)
  );

  always_comb begin
    next_state = state;
    restart    = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          restart    = 1'b1;
          clear      = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        load = byte_valid & byte_ready;
        if (load && (full || byte_last)) next_state = WRITE;
      end
      WRITE: begin
        // The word has been captured into mem_wdata; empty the packer for the next one.
        clear = 1'b1;
        if (last_seen) next_state = DONE;
        else if (mem_addr + ADDR_W'(BYTES_PER_WORD) == ADDR_W'(MEM_BYTES)) next_state = ERR;
        else next_state = FILL;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they change together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      bytes_loaded <= '0;
      last_seen    <= 1'b0;
    end else begin
      state      <= next_state;
      byte_ready <= (next_state == FILL);
      busy       <= (next_state == FILL) || (next_state == WRITE);
      done       <= (next_state == DONE);
      error      <= (next_state == ERR);
      mem_we     <= (next_state == WRITE);
      mem_wdata  <= (next_state == WRITE) ? word_nxt : '0;
      mem_be     <= (next_state == WRITE) ? be_nxt : '0;
      if (restart) begin
        mem_addr     <= '0;
        bytes_loaded <= '0;
        last_seen    <= 1'b0;
      end else begin
        if (load) bytes_loaded <= bytes_loaded + ADDR_W'(1);
        if (load && byte_last) last_seen <= 1'b1;
        if (state == WRITE && next_state == FILL)
          mem_addr <= mem_addr + ADDR_W'(BYTES_PER_WORD);
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench: table vectors, hand-written corner sequences and
// randomized streams against a word-chunking reference model.
module tb_instr_mem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct packed {
    int          sel;
    int          len;
    int          last_idx;
    int          gap_mode;
    logic [95:0] stream;
    int          exp_nw;
    logic [95:0] exp_data;
    logic [11:0] exp_be;
    bit          exp_done;
    bit          exp_err;
    int          exp_cnt;
  } vec_t;

  localparam int BUDGET = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        start[2], byte_valid[2], byte_last[2];
  logic [7:0]  byte_in[2];
  logic        byte_ready[2], mem_we[2], busy[2], done[2], error[2];
  logic [31:0] mem_addr[2], mem_wdata[2], bytes_loaded[2];
  logic [3:0]  mem_be[2];

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t wq[$];
  int  mem_size[2] = '{64, 8};

  always #5 clk = ~clk;

  instr_mem_loader #(.MEM_BYTES(64), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start[0]), .byte_in(byte_in[0]),
    .byte_valid(byte_valid[0]), .byte_last(byte_last[0]), .byte_ready(byte_ready[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_be(mem_be[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
    .bytes_loaded(bytes_loaded[0])
  );

  instr_mem_loader #(.MEM_BYTES(8), .ADDR_W(32)) dut8 (
    .clk(clk), .reset(reset), .start(start[1]), .byte_in(byte_in[1]),
    .byte_valid(byte_valid[1]), .byte_last(byte_last[1]), .byte_ready(byte_ready[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_be(mem_be[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
    .bytes_loaded(bytes_loaded[1])
  );

  // Only one instance is exercised at a time, so one write log suffices.
  always @(negedge clk) begin
    if (mem_we[0]) wq.push_back('{addr: mem_addr[0], data: mem_wdata[0], be: mem_be[0]});
    if (mem_we[1]) wq.push_back('{addr: mem_addr[1], data: mem_wdata[1], be: mem_be[1]});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; byte_valid[s] = 1'b0; byte_last[s] = 1'b0; byte_in[s] = 8'h00;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wq.delete();
  endtask

  task automatic check_reset_values(input string tag, input int sel);
    check({tag, ".byte_ready"}, 32'(byte_ready[sel]), 0);
    check({tag, ".mem_we"}, 32'(mem_we[sel]), 0);
    check({tag, ".mem_addr"}, mem_addr[sel], 0);
    check({tag, ".mem_wdata"}, mem_wdata[sel], 0);
    check({tag, ".mem_be"}, 32'(mem_be[sel]), 0);
    check({tag, ".busy"}, 32'(busy[sel]), 0);
    check({tag, ".done"}, 32'(done[sel]), 0);
    check({tag, ".error"}, 32'(error[sel]), 0);
    check({tag, ".bytes_loaded"}, bytes_loaded[sel], 0);
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic pulse_start(input int sel);
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input bit last);
    byte_valid[sel] = 1'b1; byte_in[sel] = b; byte_last[sel] = last;
    @(negedge clk);
    byte_valid[sel] = 1'b0; byte_last[sel] = 1'b0;
  endtask

  task automatic drive_stream(input int sel, input logic [7:0] q[$], input int last_idx,
                              input int gap_mode);
    int i = 0;
    int cyc = 0;
    bit acc;
    pulse_start(sel);
    while (i < q.size() && !done[sel] && !error[sel] && cyc < BUDGET) begin
      case (gap_mode)
        0:       byte_valid[sel] = 1'b1;
        1:       byte_valid[sel] = ((cyc % 2) == 0);
        default: byte_valid[sel] = ($urandom_range(1) == 1);
      endcase
      byte_in[sel]   = q[i];
      byte_last[sel] = (i == last_idx);
      acc = byte_valid[sel] && byte_ready[sel];
      @(negedge clk);
      cyc++;
      if (acc) i++;
    end
    byte_valid[sel] = 1'b0; byte_last[sel] = 1'b0; byte_in[sel] = 8'h00;
    if (cyc >= BUDGET) check("drive.cycle_budget_expired", 32'(cyc), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare(input string tag, input int sel, input wr_t exp_q[$],
                         input int cnt, input bit edone, input bit eerr);
    check({tag, ".num_writes"}, 32'(wq.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wq.size(); k++) begin
      check($sformatf("%s.w%0d.addr", tag, k), wq[k].addr, exp_q[k].addr);
      check($sformatf("%s.w%0d.data", tag, k), wq[k].data, exp_q[k].data);
      check($sformatf("%s.w%0d.be", tag, k), 32'(wq[k].be), 32'(exp_q[k].be));
    end
    check({tag, ".done"}, 32'(done[sel]), 32'(edone));
    check({tag, ".error"}, 32'(error[sel]), 32'(eerr));
    check({tag, ".bytes_loaded"}, bytes_loaded[sel], 32'(cnt));
    check({tag, ".byte_ready"}, 32'(byte_ready[sel]), 0);
    check({tag, ".busy"}, 32'(busy[sel]), 0);
  endtask

  // Reference: chop the accepted prefix into 4-byte big-endian words.
  task automatic model(input logic [7:0] q[$], input int last_idx, input int mem,
                       output wr_t exp_q[$], output int cnt, output bit edone, output bit eerr);
    int n;
    n = (last_idx >= 0) ? last_idx + 1 : q.size();
    exp_q.delete();
    edone = 1'b0; eerr = 1'b0;
    if (n > mem) begin cnt = mem; eerr = 1'b1; end
    else begin cnt = n; edone = (last_idx >= 0); end
    for (int w = 0; w * 4 < cnt; w++) begin
      wr_t e;
      e.addr = 32'(w * 4); e.data = '0; e.be = '0;
      for (int j = 0; j < 4; j++) begin
        if (w * 4 + j < cnt) begin
          e.data[31 - 8*j -: 8] = q[w*4 + j];
          e.be[3 - j] = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  initial begin
    vec_t       vecs[6];
    logic [7:0] q[$];
    wr_t        exp_q[$];
    int         cnt, sel, len, last_idx;
    bit         edone, eerr;

    vecs[0] = '{sel: 0, len: 8, last_idx: 7, gap_mode: 0,
                stream: 96'h84041232_25431789_00000000, exp_nw: 2,
                exp_data: 96'h84041232_25431789_00000000, exp_be: 12'hFF0,
                exp_done: 1, exp_err: 0, exp_cnt: 8};
    vecs[1] = '{sel: 0, len: 3, last_idx: 2, gap_mode: 0,
                stream: 96'h23539700_00000000_00000000, exp_nw: 1,
                exp_data: 96'h23539700_00000000_00000000, exp_be: 12'hE00,
                exp_done: 1, exp_err: 0, exp_cnt: 3};
    vecs[2] = '{sel: 1, len: 12, last_idx: -1, gap_mode: 0,
                stream: 96'h01020304_05060708_090A0B0C, exp_nw: 2,
                exp_data: 96'h01020304_05060708_00000000, exp_be: 12'hFF0,
                exp_done: 0, exp_err: 1, exp_cnt: 8};
    vecs[3] = '{sel: 0, len: 4, last_idx: 3, gap_mode: 1,
                stream: 96'hA1B2C3D4_00000000_00000000, exp_nw: 1,
                exp_data: 96'hA1B2C3D4_00000000_00000000, exp_be: 12'hF00,
                exp_done: 1, exp_err: 0, exp_cnt: 4};
    vecs[4] = '{sel: 1, len: 8, last_idx: 7, gap_mode: 1,
                stream: 96'hDEADBEEF_CAFEF00D_00000000, exp_nw: 2,
                exp_data: 96'hDEADBEEF_CAFEF00D_00000000, exp_be: 12'hFF0,
                exp_done: 1, exp_err: 0, exp_cnt: 8};
    vecs[5] = '{sel: 0, len: 1, last_idx: 0, gap_mode: 0,
                stream: 96'h5A000000_00000000_00000000, exp_nw: 1,
                exp_data: 96'h5A000000_00000000_00000000, exp_be: 12'h800,
                exp_done: 1, exp_err: 0, exp_cnt: 1};

    // Reset state of both instances.
    do_reset();
    check_reset_values("reset0", 0);
    check_reset_values("reset1", 1);

    // Table vectors.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      q.delete(); exp_q.delete();
      for (int i = 0; i < vecs[v].len; i++) q.push_back(vecs[v].stream[95 - 8*i -: 8]);
      for (int k = 0; k < vecs[v].exp_nw; k++)
        exp_q.push_back('{addr: 32'(4*k), data: vecs[v].exp_data[95 - 32*k -: 32],
                          be: vecs[v].exp_be[11 - 4*k -: 4]});
      drive_stream(vecs[v].sel, q, vecs[v].last_idx, vecs[v].gap_mode);
      compare($sformatf("vec%0d", v), vecs[v].sel, exp_q, vecs[v].exp_cnt,
              vecs[v].exp_done, vecs[v].exp_err);
    end

    // Cycle timing: ready after start, one-cycle write with ready low, ready back.
    do_reset();
    pulse_start(0);
    check("timing.ready_after_start", 32'(byte_ready[0]), 1);
    for (int i = 0; i < 4; i++) send_byte(0, 8'(8'h10 + i), 1'b0);
    check("timing.we_after_4th", 32'(mem_we[0]), 1);
    check("timing.ready_low_in_write", 32'(byte_ready[0]), 0);
    check("timing.wdata", mem_wdata[0], 32'h10111213);
    check("timing.be", 32'(mem_be[0]), 32'hF);
    @(negedge clk);
    check("timing.we_single_cycle", 32'(mem_we[0]), 0);
    check("timing.ready_back", 32'(byte_ready[0]), 1);
    check("timing.next_addr", mem_addr[0], 4);

    // Reset during the write cycle.
    do_reset();
    pulse_start(0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'(8'h40 + i), 1'b0);
    reset = 1'b1;
    #1 wq.delete();
    @(negedge clk);
    check_reset_values("rst_in_write", 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_write.no_later_we", 32'(wq.size()), 0);
    q = '{8'h29, 8'h48, 8'h19, 8'h99};
    drive_stream(0, q, -1, 0);
    check("rst_in_write.reload_nw", 32'(wq.size()), 1);
    if (wq.size() > 0) begin
      check("rst_in_write.reload_addr", wq[0].addr, 0);
      check("rst_in_write.reload_data", wq[0].data, 32'h29481999);
    end

    // start during FILL is ignored; start in DONE restarts at address 0.
    do_reset();
    pulse_start(0);
    send_byte(0, 8'hC1, 1'b0);
    send_byte(0, 8'hC2, 1'b0);
    pulse_start(0);
    check("restart.ignored_count", bytes_loaded[0], 2);
    check("restart.ignored_busy", 32'(busy[0]), 1);
    send_byte(0, 8'hC3, 1'b0);
    send_byte(0, 8'hC4, 1'b1);
    repeat (2) @(negedge clk);
    check("restart.first_done", 32'(done[0]), 1);
    check("restart.first_nw", 32'(wq.size()), 1);
    if (wq.size() > 0) check("restart.first_data", wq[0].data, 32'hC1C2C3C4);
    wq.delete();
    pulse_start(0);
    check("restart.done_cleared", 32'(done[0]), 0);
    check("restart.count_cleared", bytes_loaded[0], 0);
    check("restart.ready", 32'(byte_ready[0]), 1);
    send_byte(0, 8'h77, 1'b1);
    repeat (2) @(negedge clk);
    check("restart.second_nw", 32'(wq.size()), 1);
    if (wq.size() > 0) begin
      check("restart.second_addr", wq[0].addr, 0);
      check("restart.second_data", wq[0].data, 32'h77000000);
      check("restart.second_be", 32'(wq[0].be), 32'h8);
    end

    // Randomized streams against the reference model.
    for (int it = 0; it < 24; it++) begin
      do_reset();
      sel = int'($urandom_range(1));
      q.delete();
      if ($urandom_range(9) < 7) begin
        len = int'($urandom_range(1, (sel == 0) ? 16 : 12));
        last_idx = int'($urandom_range(0, len - 1));
      end else begin
        len = mem_size[sel] + int'($urandom_range(1, 6));
        last_idx = -1;
      end
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      model(q, last_idx, mem_size[sel], exp_q, cnt, edone, eerr);
      drive_stream(sel, q, last_idx, int'($urandom_range(2)));
      compare($sformatf("rand%0d", it), sel, exp_q, cnt, edone, eerr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
